// File: rtl/i2s_tdm_clock_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types, constants and helpers for the I2S/TDM
//                serial-clock master.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Frame formats selectable through FRAME_MODE.
    typedef enum logic [1:0] {
        FM_I2S = 2'd0,
        FM_LJ  = 2'd1,
        FM_TDM = 2'd2
    } frame_mode_e;

    // Generator control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } clk_state_e;

    // Rounded NCO increment: f_mclk * 2^phase_w / f_sys.
    function automatic longint unsigned calc_phase_inc(
        input longint unsigned f_sys,
        input longint unsigned f_mclk,
        input int unsigned     phase_w
    );
        longint unsigned num;
        num = (f_mclk << phase_w) + (f_sys >> 1);
        return num / f_sys;
    endfunction

    // 720p defaults: 74.25 MHz system clock, 12.288 MHz MCLK (256 x 48 kHz).
    localparam int unsigned     c_PHASE_W_DEFAULT = 32;
    localparam longint unsigned c_F_SYS_720P      = 64'd74_250_000;
    localparam longint unsigned c_F_MCLK_48K      = 64'd12_288_000;
    localparam longint unsigned c_PHASE_INC_720P  =
        calc_phase_inc(c_F_SYS_720P, c_F_MCLK_48K, c_PHASE_W_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/i2s_tdm_clock_gen_nco_clock.sv
`default_nettype none
// ============================================================================
//  Module      : nco_clock
//  Description : Fractional phase accumulator producing a registered MCLK
//                and a one-cycle strobe coinciding with its rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_clock #(
    parameter int PHASE_W = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               i_start,
    input  logic               i_load,
    input  logic               i_run,
    input  logic [PHASE_W-1:0] i_inc,
    output logic               o_mclk,
    output logic               o_mclk_rise
);
    import i2s_pkg::*;

    // Half of full scale: the largest step that still yields a square MCLK.
    localparam logic [PHASE_W-1:0] c_INC_MAX = {1'b1, {(PHASE_W-1){1'b0}}};

    logic [PHASE_W-1:0] r_acc;
    logic [PHASE_W-1:0] r_inc;
    logic [PHASE_W-1:0] w_inc_sat;
    logic               r_mclk;
    logic               r_rise;

    assign w_inc_sat = (i_inc > c_INC_MAX) ? c_INC_MAX : i_inc;

    // Increment is captured only at start and at frame boundaries.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_inc <= '0;
        end else if (i_start || i_load) begin
            r_inc <= w_inc_sat;
        end
    end

    // Accumulate while running; the MSB, delayed one cycle, is MCLK.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_acc  <= '0;
            r_mclk <= 1'b0;
            r_rise <= 1'b0;
        end else if (i_start || !i_run) begin
            r_acc  <= '0;
            r_mclk <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_acc  <= r_acc + r_inc;
            r_mclk <= r_acc[PHASE_W-1];
            r_rise <= r_acc[PHASE_W-1] & ~r_mclk;
        end
    end

    assign o_mclk      = r_mclk;
    assign o_mclk_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/i2s_tdm_clock_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tdm_clock_gen
//  Description : I2S / left-justified / TDM clock master. Derives MCLK, BCK
//                and LRCK from sys_clk via a fractional NCO and exports
//                sys_clk-domain strobes and slot/bit counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_clock_gen #(
    parameter int PHASE_W      = 32,
    parameter int MCLK_PER_BCK = 4,
    parameter int SLOT_BITS    = 32,
    parameter int NUM_SLOTS    = 2,
    parameter int FRAME_MODE   = 0
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         enable,
    input  logic [PHASE_W-1:0]           phase_inc,
    output logic                         mclk_out,
    output logic                         bck_out,
    output logic                         lrck_out,
    output logic                         bck_rise,
    output logic                         bck_fall,
    output logic                         frame_start,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         running
);
    import i2s_pkg::*;

    localparam int c_HALF   = MCLK_PER_BCK / 2;
    localparam int c_DIV_W  = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam int c_BIT_W  = $clog2(SLOT_BITS);
    localparam int c_SLOT_W = $clog2(NUM_SLOTS);

    localparam logic [c_DIV_W-1:0]  c_DIV_MAX     = c_DIV_W'(c_HALF - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_MAX     = c_BIT_W'(SLOT_BITS - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_MAX    = c_SLOT_W'(NUM_SLOTS - 1);
    localparam logic [c_SLOT_W-1:0] c_SLOT_HALF   = c_SLOT_W'(NUM_SLOTS / 2);
    localparam logic [c_SLOT_W-1:0] c_SLOT_HALF_M = c_SLOT_W'(NUM_SLOTS / 2 - 1);
    localparam frame_mode_e         c_MODE        = frame_mode_e'(2'(FRAME_MODE));

    clk_state_e          r_state;
    clk_state_e          w_state_nxt;
    logic [c_DIV_W-1:0]  r_div;
    logic                r_bck;
    logic                r_bck_rise;
    logic                r_bck_fall;
    logic                r_fs;
    logic                r_lrck;
    logic                r_first;
    logic [c_SLOT_W-1:0] r_slot;
    logic [c_BIT_W-1:0]  r_bit;

    logic                w_mclk;
    logic                w_mclk_rise;
    logic                w_bck_tick;
    logic                w_rise_evt;
    logic                w_fall_evt;
    logic                w_wrap;
    logic                w_frame_evt;
    logic                w_start;
    logic                w_active_nxt;
    logic [c_SLOT_W-1:0] w_slot_nxt;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic                w_last_bit_nxt;
    logic                w_lrck_nxt;

    // First fall after start keeps slot 0 / bit 0 and opens the first frame.
    assign w_bck_tick   = w_mclk_rise && (r_div == c_DIV_MAX);
    assign w_rise_evt   = w_bck_tick && !r_bck;
    assign w_fall_evt   = w_bck_tick && r_bck;
    assign w_wrap       = r_first || ((r_bit == c_BIT_MAX) && (r_slot == c_SLOT_MAX));
    assign w_frame_evt  = w_fall_evt && w_wrap;
    assign w_start      = (r_state == ST_IDLE) && enable;
    assign w_active_nxt = (w_state_nxt != ST_IDLE);

    nco_clock #(
        .PHASE_W     (PHASE_W)
    ) u_nco (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .i_start     (w_start),
        .i_load      (w_frame_evt),
        .i_run       (w_active_nxt),
        .i_inc       (phase_inc),
        .o_mclk      (w_mclk),
        .o_mclk_rise (w_mclk_rise)
    );

    // Position that becomes current on the next bck_fall.
    always_comb begin
        w_slot_nxt = r_slot;
        w_bit_nxt  = r_bit;
        if (w_wrap) begin
            w_slot_nxt = '0;
            w_bit_nxt  = '0;
        end else if (r_bit == c_BIT_MAX) begin
            w_bit_nxt  = '0;
            w_slot_nxt = r_slot + 1'b1;
        end else begin
            w_bit_nxt  = r_bit + 1'b1;
        end
    end

    // LRCK level for the upcoming position, per frame format.
    always_comb begin
        w_last_bit_nxt = (w_bit_nxt == c_BIT_MAX);
        w_lrck_nxt     = 1'b0;
        if (c_MODE == FM_I2S) begin
            if (w_slot_nxt >= c_SLOT_HALF) begin
                w_lrck_nxt = !((w_slot_nxt == c_SLOT_MAX) && w_last_bit_nxt);
            end else begin
                w_lrck_nxt = (w_slot_nxt == c_SLOT_HALF_M) && w_last_bit_nxt;
            end
        end else if (c_MODE == FM_LJ) begin
            w_lrck_nxt = (w_slot_nxt < c_SLOT_HALF);
        end else begin
            w_lrck_nxt = (w_slot_nxt == c_SLOT_MAX) && w_last_bit_nxt;
        end
    end

    // Control state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: drain finishes at the fall that would open a new frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
            ST_RUN:   if (!enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (enable) begin
                    w_state_nxt = ST_RUN;
                end else if (w_frame_evt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // BCK divider, strobes, slot/bit counters and LRCK.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_div      <= '0;
            r_bck      <= 1'b0;
            r_bck_rise <= 1'b0;
            r_bck_fall <= 1'b0;
            r_fs       <= 1'b0;
            r_lrck     <= 1'b0;
            r_first    <= 1'b1;
            r_slot     <= '0;
            r_bit      <= '0;
        end else if (w_start || !w_active_nxt) begin
            r_div      <= '0;
            r_bck      <= 1'b0;
            r_bck_rise <= 1'b0;
            r_bck_fall <= 1'b0;
            r_fs       <= 1'b0;
            r_lrck     <= 1'b0;
            r_first    <= 1'b1;
            r_slot     <= '0;
            r_bit      <= '0;
        end else begin
            r_bck_rise <= w_rise_evt;
            r_bck_fall <= w_fall_evt;
            r_fs       <= w_frame_evt;
            if (w_mclk_rise) begin
                r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + 1'b1;
            end
            if (w_bck_tick) begin
                r_bck <= ~r_bck;
            end
            if (w_fall_evt) begin
                r_slot  <= w_slot_nxt;
                r_bit   <= w_bit_nxt;
                r_lrck  <= w_lrck_nxt;
                r_first <= 1'b0;
            end
        end
    end

    assign mclk_out    = w_mclk;
    assign bck_out     = r_bck;
    assign lrck_out    = r_lrck;
    assign bck_rise    = r_bck_rise;
    assign bck_fall    = r_bck_fall;
    assign frame_start = r_fs;
    assign slot_idx    = r_slot;
    assign bit_idx     = r_bit;
    assign running     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
